// File: rtl/pcie_tx_arb_pkg.sv
// Shared types for the PCIe TX port arbiter: FSM encoding and grant-owner IDs.
package pcie_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_APP = 2'd1,
    GNT_INJ = 2'd2
  } arb_state_t;

  localparam logic GNT_APP_ID = 1'b0;
  localparam logic GNT_INJ_ID = 1'b1;

endpackage

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the core's AXI4-Stream TX port
// between the PIO completion engine (req/ack) and the Ethernet TLP inject path.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 64,
  parameter int KEEP_WIDTH     = C_DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst_n,
  input  logic                    user_lnk_up,

  input  logic                    app_req,
  output logic                    app_ack,
  output logic                    app_tready,
  input  logic                    app_tvalid,
  input  logic                    app_tlast,
  input  logic [KEEP_WIDTH-1:0]   app_tkeep,
  input  logic [C_DATA_WIDTH-1:0] app_tdata,
  input  logic [3:0]              app_tuser,

  output logic                    inj_tready,
  input  logic                    inj_tvalid,
  input  logic                    inj_tlast,
  input  logic [KEEP_WIDTH-1:0]   inj_tkeep,
  input  logic [C_DATA_WIDTH-1:0] inj_tdata,
  input  logic [3:0]              inj_tuser,

  input  logic                    tx_tready,
  output logic                    tx_tvalid,
  output logic                    tx_tlast,
  output logic [KEEP_WIDTH-1:0]   tx_tkeep,
  output logic [C_DATA_WIDTH-1:0] tx_tdata,
  output logic [3:0]              tx_tuser,

  output logic                    app_timeout,
  output logic [CNT_WIDTH-1:0]    app_pkt_cnt,
  output logic [CNT_WIDTH-1:0]    inj_pkt_cnt
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t      state, state_nxt;
  logic            last_gnt;
  logic            started;
  logic [TO_W-1:0] tmo_cnt;
  logic            tmo_expire;
  logic            app_beat, inj_beat;

  // Handshake: a beat transfers on a rising edge where the granted source's
  // tvalid and the core's tx_tready are both high; tready is a pure
  // pass-through of tx_tready to the granted source and 0 to the other.
  assign app_beat = app_tvalid & tx_tready;
  assign inj_beat = inj_tvalid & tx_tready;

  always_comb begin
    state_nxt  = state;
    tmo_expire = 1'b0;
    case (state)
      IDLE: begin
        if (user_lnk_up) begin
          if (app_req && (!inj_tvalid || last_gnt == GNT_INJ_ID)) state_nxt = GNT_APP;
          else if (inj_tvalid)                                     state_nxt = GNT_INJ;
        end
      end
      GNT_APP: begin
        // Once the first beat is in, the packet always runs to tlast.
        if (app_beat && app_tlast) begin
          state_nxt = IDLE;
        end else if (!started && !app_beat) begin
          if (!app_req) begin
            state_nxt = IDLE;
          end else if (tmo_cnt == '0) begin
            state_nxt  = IDLE;
            tmo_expire = 1'b1;
          end
        end
      end
      GNT_INJ: begin
        if (inj_beat && inj_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state       <= IDLE;
      last_gnt    <= GNT_INJ_ID;
      started     <= 1'b0;
      tmo_cnt     <= TO_LOAD;
      app_timeout <= 1'b0;
      app_pkt_cnt <= '0;
      inj_pkt_cnt <= '0;
    end else begin
      state       <= state_nxt;
      app_timeout <= tmo_expire;
      if (state == IDLE && state_nxt != IDLE) begin
        last_gnt <= (state_nxt == GNT_INJ) ? GNT_INJ_ID : GNT_APP_ID;
        started  <= 1'b0;
        tmo_cnt  <= TO_LOAD;
      end else if (state == GNT_APP) begin
        if (app_beat)              started <= 1'b1;
        else if (tmo_cnt != '0)    tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (state == GNT_APP && app_beat && app_tlast) app_pkt_cnt <= app_pkt_cnt + 1'b1;
      if (state == GNT_INJ && inj_beat && inj_tlast) inj_pkt_cnt <= inj_pkt_cnt + 1'b1;
    end
  end

  assign app_ack = (state == GNT_APP);

  always_comb begin
    tx_tvalid  = 1'b0;
    tx_tlast   = 1'b0;
    tx_tkeep   = '0;
    tx_tdata   = '0;
    tx_tuser   = '0;
    app_tready = 1'b0;
    inj_tready = 1'b0;
    case (state)
      GNT_APP: begin
        tx_tvalid  = app_tvalid;
        tx_tlast   = app_tlast;
        tx_tkeep   = app_tkeep;
        tx_tdata   = app_tdata;
        tx_tuser   = app_tuser;
        app_tready = tx_tready;
      end
      GNT_INJ: begin
        tx_tvalid  = inj_tvalid;
        tx_tlast   = inj_tlast;
        tx_tkeep   = inj_tkeep;
        tx_tdata   = inj_tdata;
        tx_tuser   = inj_tuser;
        inj_tready = tx_tready;
      end
      default: ;
    endcase
  end

endmodule
